// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the slurm16 memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_VID  = 0;
    localparam int unsigned PORT_CPU  = 1;
    localparam int unsigned PORT_SPR  = 2;
    localparam int unsigned PORT_DMA  = 3;

    typedef struct packed {
        logic       valid;
        logic [1:0] owner;
    } lock_state_t;

endpackage

// File: rtl/mem_arb_rr3.sv
// Round-robin picker over ports 1-3; search starts at the port after rr_ptr.
module mem_arb_rr3 (
    input  logic [2:0] req_mask,
    input  logic [1:0] rr_ptr,
    output logic [2:0] win
);

    // req_mask/win bit 0 corresponds to port 1
    always_comb begin
        win = 3'b000;
        case (rr_ptr)
            2'd1: begin
                if (req_mask[1])      win = 3'b010;
                else if (req_mask[2]) win = 3'b100;
                else if (req_mask[0]) win = 3'b001;
            end
            2'd2: begin
                if (req_mask[2])      win = 3'b100;
                else if (req_mask[0]) win = 3'b001;
                else if (req_mask[1]) win = 3'b010;
            end
            default: begin
                if (req_mask[0])      win = 3'b001;
                else if (req_mask[1]) win = 3'b010;
                else if (req_mask[2]) win = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: port 0 fixed priority with starvation guard, ports 1-3 round-robin
// with locked bursts. Define MEM_ARB_STATS_EN to add per-port saturating grant counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned VID_RUN_MAX = 8,
    parameter int unsigned LOCK_MAX    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            req_i,
    input  logic [3:0]            lock_i,
    input  logic [3:0]            wr_i,
    input  logic [4*ADDR_W-1:0]   addr_i,
    input  logic [4*DATA_W-1:0]   wdata_i,
    output logic [3:0]            gnt_o,
    output logic [3:0]            rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
`ifdef MEM_ARB_STATS_EN
    output logic [4*16-1:0]       stat_gnt_o,
`endif
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int unsigned VRW = (VID_RUN_MAX < 1) ? 1 : $clog2(VID_RUN_MAX + 1);
    localparam int unsigned LCW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

    logic [VRW-1:0]    vid_run_q, vid_run_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    lock_state_t       lock_q, lock_d;
    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [3:0]        excl_q, excl_d;
    logic [3:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic       owner_ok, lock_drop, owner_gnt, guard_fire, req_lo;
    logic [3:0] excl_now, gnt;
    logic [2:0] rr_req, rr_win;

    always_comb begin
        owner_ok  = lock_q.valid & req_i[lock_q.owner] & lock_i[lock_q.owner];
        lock_drop = lock_q.valid & ~owner_ok;
        excl_now  = excl_q;
        if (lock_drop) excl_now[lock_q.owner] = 1'b1;
        rr_req    = req_i[3:1] & ~excl_now[3:1];
        req_lo    = |req_i[3:1];
    end

    mem_arb_rr3 u_rr3 (
        .req_mask (rr_req),
        .rr_ptr   (rr_ptr_q),
        .win      (rr_win)
    );

    // Guard only masks port 0 when someone else can actually take the slot.
    assign guard_fire = (VID_RUN_MAX != 0) && (vid_run_q == VRW'(VID_RUN_MAX)) && req_lo &&
                        (owner_ok || (|rr_win));

    always_comb begin
        gnt = 4'b0000;
        if (owner_ok && (!req_i[0] || guard_fire)) gnt[lock_q.owner] = 1'b1;
        else if (req_i[0] && !guard_fire)         gnt[0] = 1'b1;
        else                                       gnt[3:1] = rr_win;
        owner_gnt = owner_ok & gnt[lock_q.owner];
    end

    always_comb begin
        vid_run_d  = vid_run_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        excl_d     = 4'b0000;

        if (!req_lo || (|gnt[3:1])) vid_run_d = '0;
        else if (gnt[0] && (vid_run_q != VRW'(VID_RUN_MAX))) vid_run_d = vid_run_q + 1'b1;

        if (gnt[1])      rr_ptr_d = 2'd1;
        else if (gnt[2]) rr_ptr_d = 2'd2;
        else if (gnt[3]) rr_ptr_d = 2'd3;

        if (lock_drop) begin
            lock_d.valid = 1'b0;
            lock_cnt_d   = '0;
        end else if (owner_gnt) begin
            if (lock_cnt_q == LCW'(LOCK_MAX - 1)) begin
                lock_d.valid           = 1'b0;
                lock_cnt_d             = '0;
                excl_d[lock_q.owner]   = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end

        // A fresh lock can start on the same cycle an old one drops.
        if ((!lock_q.valid || lock_drop) && (LOCK_MAX > 1)) begin
            for (int p = 1; p < NUM_PORTS; p++) begin
                if (gnt[p] && lock_i[p]) begin
                    lock_d.valid = 1'b1;
                    lock_d.owner = 2'(p);
                    lock_cnt_d   = LCW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vid_run_q  <= '0;
            rr_ptr_q   <= 2'd3;
            lock_q     <= '0;
            lock_cnt_q <= '0;
            excl_q     <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            vid_run_q  <= vid_run_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            excl_q     <= excl_d;
            rvalid_q   <= gnt & ~wr_i;
            rdata_q    <= mem_rdata_i;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                mem_addr_o  = addr_i[p*ADDR_W +: ADDR_W];
                mem_wdata_o = wdata_i[p*DATA_W +: DATA_W];
            end
        end
    end

    assign gnt_o    = gnt;
    assign mem_en_o = |gnt;
    assign mem_we_o = |(gnt & wr_i);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [NUM_PORTS-1:0][15:0] stat_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p] && (stat_q[p] != 16'hFFFF)) stat_q[p] <= stat_q[p] + 16'd1;
            end
        end
    end

    assign stat_gnt_o = stat_q;
`endif

endmodule
